// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and bit-timing helpers.
package uart_rx_fifo_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } rx_state_t;

   function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

   function automatic int half_bit(input int clk_freq, input int baud_rate);
      return clks_per_bit(clk_freq, baud_rate) / 2;
   endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count; a push into a full
// FIFO is accepted only when a pop happens in the same cycle, otherwise it is dropped.
module sync_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     wr_en,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     rd_en,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     valid,
   output logic                     wr_drop,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              push;
   logic              pop;

   assign pop     = rd_en && (count != '0);
   assign push    = wr_en && ((count != FULL_CNT) || pop);
   assign wr_drop = wr_en && !push;
   assign valid   = (count != '0);
   // Head is forced to zero while empty so the output is defined out of reset.
   assign rd_data = valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling FSM, FWFT byte FIFO and
// sticky framing/overrun flags.
module uart_rx_fifo
   import uart_rx_fifo_pkg::*;
#(
   parameter int BAUD_RATE  = 115200,
   parameter int CLK_FREQ   = 100000000,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          uart_rxd,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [7:0]                    m_data,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          frame_err,
   output logic                          overrun,
   input  logic                          err_clr
);

   localparam int CPB  = clks_per_bit(CLK_FREQ, BAUD_RATE);
   localparam int HALF = half_bit(CLK_FREQ, BAUD_RATE);
   localparam int TW   = $clog2(CPB) + 1;
   localparam logic [TW-1:0] FULL_TICK = TW'(CPB - 1);
   localparam logic [TW-1:0] HALF_TICK = TW'(HALF - 1);

   logic          rxd_p0;
   logic          rxd_p1;
   rx_state_t     state;
   logic [TW-1:0] timer;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          tick;
   logic          push_req;
   logic          ferr_evt;
   logic          drop_evt;

   // Stage p0/p1: metastability guard; the line idles high.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rxd_p0 <= 1'b1;
         rxd_p1 <= 1'b1;
      end else begin
         rxd_p0 <= uart_rxd;
         rxd_p1 <= rxd_p0;
      end
   end

   assign tick     = (state == START) ? (timer == HALF_TICK) : (timer == FULL_TICK);
   assign push_req = (state == STOP) && tick && rxd_p1;
   assign ferr_evt = (state == STOP) && tick && !rxd_p1;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= IDLE;
         timer   <= '0;
         bit_idx <= '0;
      end else begin
         case (state)
            IDLE: begin
               timer <= '0;
               if (!rxd_p1) state <= START;
            end
            START: begin
               if (tick) begin
                  timer   <= '0;
                  bit_idx <= '0;
                  state   <= rxd_p1 ? IDLE : DATA;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            DATA: begin
               if (tick) begin
                  timer   <= '0;
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) state <= STOP;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            STOP: begin
               if (tick) begin
                  timer <= '0;
                  // Returning to IDLE mid-stop-bit leaves room to catch an immediate next start.
                  state <= rxd_p1 ? IDLE : BREAK;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            BREAK: begin
               timer <= '0;
               if (rxd_p1) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == DATA && tick) shreg <= {rxd_p1, shreg[7:1]};
   end

   sync_fifo #(
      .DATA_W (8),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .wr_en   (push_req),
      .wr_data (shreg),
      .rd_en   (m_ready),
      .rd_data (m_data),
      .valid   (m_valid),
      .wr_drop (drop_evt),
      .count   (fifo_count)
   );

   // A new error in the clearing cycle wins over err_clr.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= ferr_evt | (frame_err & ~err_clr);
         overrun   <= drop_evt | (overrun & ~err_clr);
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised and directed bench for uart_rx_fifo against a frame-level FIFO/flag model.
module tb_uart_rx_fifo;

   localparam int CLK_FREQ  = 1600000;
   localparam int BAUD_RATE = 100000;
   localparam int DEPTH     = 4;
   localparam int CPB       = CLK_FREQ / BAUD_RATE;
   // Stop-bit decision edge counted from the edge the start bit is driven after:
   // 2 synchroniser edges, 1 edge to leave IDLE, half a bit, then 9 full bits.
   localparam int STOP_EDGE = 3 + CPB / 2 + 9 * CPB;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       uart_rxd = 1'b1;
   logic       m_valid;
   logic       m_ready = 1'b0;
   logic [7:0] m_data;
   logic [2:0] fifo_count;
   logic       frame_err;
   logic       overrun;
   logic       err_clr = 1'b0;

   int n_checks = 0;
   int n_err = 0;
   int pops = 0;
   logic [7:0] model_q[$];
   logic exp_ferr = 1'b0;
   logic exp_ovr = 1'b0;

   always #5 clk = ~clk;

   uart_rx_fifo #(
      .BAUD_RATE  (BAUD_RATE),
      .CLK_FREQ   (CLK_FREQ),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .uart_rxd   (uart_rxd),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .fifo_count (fifo_count),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .err_clr    (err_clr)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs are driven 1 time unit after posedge; outputs are sampled at negedge.
   always @(negedge clk) begin
      if (resetn && m_valid && m_ready) begin
         pops++;
         if (model_q.size() == 0) chk("pop_unexpected", 32'(m_data), 32'hFFFF_FFFF);
         else chk("pop_data", 32'(m_data), 32'(model_q.pop_front()));
      end
   end

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // pulse_at >= 0: m_ready high only in that cycle; -2: random m_ready; -1: untouched.
   task automatic send_frame(input logic [7:0] b, input logic stop_b, input int pulse_at);
      for (int c = 0; c < 10 * CPB; c++) begin
         int k;
         k = c / CPB;
         uart_rxd = (k == 0) ? 1'b0 : (k == 9) ? stop_b : b[k-1];
         if (pulse_at >= 0) m_ready = (c == pulse_at);
         else if (pulse_at == -2) m_ready = 1'($urandom_range(0, 1));
         if (c == STOP_EDGE) begin
            if (!stop_b) exp_ferr = 1'b1;
            else if (model_q.size() < DEPTH) model_q.push_back(b);
            else exp_ovr = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      if (pulse_at != -1) m_ready = 1'b0;
   endtask

   task automatic drain(input string tag);
      int budget;
      budget = 200;
      m_ready = 1'b1;
      while (m_valid && budget > 0) begin
         cycles(1);
         budget--;
      end
      m_ready = 1'b0;
      cycles(1);
      chk({tag, "_empty"}, 32'(m_valid), 32'd0);
      chk({tag, "_model_empty"}, 32'(model_q.size()), 32'd0);
   endtask

   task automatic clear_flags();
      err_clr = 1'b1;
      cycles(1);
      err_clr = 1'b0;
      exp_ferr = 1'b0;
      exp_ovr = 1'b0;
      cycles(1);
   endtask

   initial begin
      int p0;
      cycles(3);
      chk("rst_valid", 32'(m_valid), 32'd0);
      chk("rst_data", 32'(m_data), 32'd0);
      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_ferr", 32'(frame_err), 32'd0);
      chk("rst_ovr", 32'(overrun), 32'd0);
      resetn = 1'b1;
      cycles(5);

      // Single frame with consumer ready
      p0 = pops;
      m_ready = 1'b1;
      send_frame(8'hA5, 1'b1, -1);
      cycles(10);
      m_ready = 1'b0;
      chk("a5_pops", 32'(pops - p0), 32'd1);
      chk("a5_count", 32'(fifo_count), 32'd0);
      chk("a5_ferr", 32'(frame_err), 32'd0);
      chk("a5_ovr", 32'(overrun), 32'd0);

      // Short low glitch must not produce a byte
      uart_rxd = 1'b0;
      cycles(4);
      uart_rxd = 1'b1;
      cycles(30);
      chk("glitch_count", 32'(fifo_count), 32'd0);
      chk("glitch_ferr", 32'(frame_err), 32'd0);
      chk("glitch_ovr", 32'(overrun), 32'd0);
      p0 = pops;
      m_ready = 1'b1;
      send_frame(8'h3C, 1'b1, -1);
      cycles(10);
      m_ready = 1'b0;
      chk("glitch_next_pops", 32'(pops - p0), 32'd1);

      // Overrun: five frames into a four-entry FIFO
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, -1);
      cycles(5);
      chk("ovr_count", 32'(fifo_count), 32'd4);
      chk("ovr_flag", 32'(overrun), 32'(exp_ovr));
      chk("ovr_flag_set", 32'(overrun), 32'd1);
      p0 = pops;
      drain("ovr");
      chk("ovr_pops", 32'(pops - p0), 32'd4);
      clear_flags();
      chk("ovr_clr", 32'(overrun), 32'd0);

      // Framing error followed by a line break
      send_frame(8'h3C, 1'b0, -1);
      cycles(40);
      uart_rxd = 1'b1;
      cycles(5);
      chk("ferr_flag", 32'(frame_err), 32'(exp_ferr));
      chk("ferr_set", 32'(frame_err), 32'd1);
      chk("ferr_count", 32'(fifo_count), 32'd0);
      p0 = pops;
      m_ready = 1'b1;
      send_frame(8'h5A, 1'b1, -1);
      cycles(10);
      m_ready = 1'b0;
      chk("ferr_next_pops", 32'(pops - p0), 32'd1);
      clear_flags();
      chk("ferr_clr", 32'(frame_err), 32'd0);

      // Full FIFO with a pop in the exact stop-sample cycle
      for (int i = 0; i < 4; i++) send_frame(8'h40 + 8'(i), 1'b1, -1);
      send_frame(8'h77, 1'b1, STOP_EDGE - 1);
      cycles(3);
      chk("sim_count", 32'(fifo_count), 32'd4);
      chk("sim_ovr", 32'(overrun), 32'd0);
      drain("sim");

      // Reset in the middle of a frame with two bytes queued
      send_frame(8'h11, 1'b1, -1);
      send_frame(8'h22, 1'b1, -1);
      for (int c = 0; c < 4 * CPB; c++) begin
         uart_rxd = (c < CPB) ? 1'b0 : 1'(8'h96 >> (c / CPB - 1));
         cycles(1);
      end
      resetn = 1'b0;
      #1;
      chk("mrst_valid", 32'(m_valid), 32'd0);
      chk("mrst_count", 32'(fifo_count), 32'd0);
      chk("mrst_ferr", 32'(frame_err), 32'd0);
      chk("mrst_ovr", 32'(overrun), 32'd0);
      model_q.delete();
      exp_ferr = 1'b0;
      exp_ovr = 1'b0;
      uart_rxd = 1'b1;
      cycles(2);
      resetn = 1'b1;
      cycles(10);
      p0 = pops;
      m_ready = 1'b1;
      send_frame(8'hC3, 1'b1, -1);
      cycles(10);
      m_ready = 1'b0;
      chk("mrst_next_pops", 32'(pops - p0), 32'd1);
      chk("mrst_next_count", 32'(fifo_count), 32'd0);

      // Randomised traffic with random back-pressure
      for (int i = 0; i < 14; i++) begin
         send_frame(8'($urandom), 1'b1, -2);
         uart_rxd = 1'b1;
         cycles($urandom_range(0, 6));
      end
      cycles(3);
      chk("rnd_count", 32'(fifo_count), 32'(model_q.size()));
      chk("rnd_ovr", 32'(overrun), 32'(exp_ovr));
      chk("rnd_ferr", 32'(frame_err), 32'(exp_ferr));
      drain("rnd");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
